count_uart_tx: RTL and testbench
================================

COUNT_UART_TX -- requirements
Module: count_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 104, meaning clock cycles per serial bit; legal range 1..65535.
REQ-002 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port in_data  input  8  byte to transmit, normally the counter value from uo_out.
REQ-005 SHALL have port in_valid  input  1  producer has a byte on in_data.
REQ-006 SHALL have port in_ready  output  1  block can accept a byte this cycle.
REQ-007 SHALL have port tx  output  1  serial line, 8N1, idle high.
REQ-008 SHALL have port busy  output  1  a frame is being shifted or a byte is buffered.
REQ-009 SHALL have port tx_done  output  1  one-cycle pulse in the last cycle of each stop bit.

Function
REQ-010 SHALL accept a byte on a rising edge where in_valid and in_ready are both high; no other edge transfers data.
REQ-011 SHALL drive in_ready = NOT buf_full, where buf_full marks a one-entry holding buffer; in_ready is independent of in_valid.
REQ-012 SHALL implement an FSM with states IDLE, START, DATA, STOP.
REQ-013 SHALL, on acceptance in IDLE, load the shifter directly, leave the buffer empty, and drive tx=0 (START) from the next cycle.
REQ-014 SHALL, on acceptance in START/DATA/STOP, store the byte in the buffer and set buf_full.
REQ-015 SHALL hold each of START, each DATA bit and STOP for exactly CLKS_PER_BIT cycles; frame = 10*CLKS_PER_BIT cycles.
REQ-016 SHALL send data bits LSB first, DATA lasting 8 bit periods tracked by a 3-bit index.
REQ-017 SHALL drive tx=1 in STOP and IDLE.
REQ-018 SHALL, at the end of STOP with buf_full=1, move the buffer into the shifter, clear buf_full, and enter START the next cycle with no idle gap.
REQ-019 SHALL, at the end of STOP with buf_full=0 and an acceptance on that same edge, treat the byte as an IDLE acceptance (REQ-013), with no idle gap.
REQ-020 SHALL, at the end of STOP with no buffered or accepted byte, return to IDLE.
REQ-021 SHALL assert tx_done exactly once per frame, in the last STOP cycle.
REQ-022 SHALL drive busy = (state != IDLE) OR buf_full.
REQ-023 SHALL ignore in_data whenever no acceptance occurs; the buffered byte is never overwritten.
REQ-024 SHALL, with CLKS_PER_BIT=1, change tx every cycle with no skipped or repeated bit.

Reset
REQ-025 SHALL, on a rising edge with rst_n=0, set state=IDLE, tx=1, buf_full=0, in_ready=1, busy=0, tx_done=0, baud counter=0, bit index=0.
REQ-026 SHALL abort any frame in progress on reset and discard the buffered byte; tx returns high on the first reset edge.
REQ-027 SHALL not accept a byte on any edge where rst_n=0.

Structure
REQ-028 SHALL place the FSM state encoding, frame length constant (10) and data-bit width (8) in a shared package.
REQ-029 SHALL use one sub-module, uart_baud_gen, a counter producing a one-cycle bit_tick every CLKS_PER_BIT cycles, restarted on frame start.
REQ-030 SHALL register tx directly from a flop, with no combinational path from inputs to tx.

Verification (bench uses CLKS_PER_BIT=4)
REQ-031 SHALL check reset: rst_n low 2 cycles -> tx=1, in_ready=1, busy=0, tx_done=0.
REQ-032 SHALL check single byte 0xA5 -> tx per 4-cycle bit = 0,1,0,1,0,0,1,0,1,1; tx_done once at cycle 40; busy low afterwards.
REQ-033 SHALL check back-to-back 0x00 then 0xFF, in_valid held high -> second byte accepted in frame 1, in_ready low until cycle 40, 80 contiguous cycles, no idle gap, two tx_done pulses.
REQ-034 SHALL check backpressure: third byte offered while buffer full -> not accepted until in_ready rises; all three bytes emitted in order.
REQ-035 SHALL check reset mid-DATA of byte 0x3C with 0x81 buffered -> tx=1 next edge, buffer empty, neither byte emitted afterwards.
REQ-036 SHALL check CLKS_PER_BIT=1 with 0x55 -> tx = 0,1,0,1,0,1,0,1,0,1 on consecutive cycles.

Source files
------------

// File: rtl/count_uart_tx_pkg.sv
// Shared types and frame geometry for the 8N1 counter-value UART transmitter.
package count_uart_tx_pkg;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned FRAME_BITS = 10;
  localparam int unsigned IDX_W      = $clog2(DATA_BITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter; bit_tick is a registered flag marking the last cycle of each bit period.
module uart_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic run,
  output logic bit_tick
);

  localparam int unsigned     CNT_W = 16;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  // Count up while a frame runs, wrap after the last cycle of a bit, hold at zero when idle.
  always_comb begin
    cnt_next = '0;
    if (run && !restart && !bit_tick) begin
      cnt_next = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      bit_tick <= 1'b0;
    end else begin
      cnt      <= cnt_next;
      bit_tick <= (restart || run) && (cnt_next == LAST);
    end
  end

endmodule

// File: rtl/count_uart_tx.sv
// 8N1 serial transmitter with a one-entry holding buffer for back-to-back frames.
module count_uart_tx
  import count_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  state_t               state;
  logic [DATA_BITS-1:0] shifter;
  logic [DATA_BITS-1:0] hold;
  logic                 buf_full;
  logic [IDX_W-1:0]     bit_idx;
  logic                 bit_tick;
  logic                 accept;
  logic                 restart;
  logic                 stop_end;

  always_comb begin
    accept   = in_valid && !buf_full;
    stop_end = (state == STOP) && bit_tick;
    restart  = ((state == IDLE) && accept) || (stop_end && (buf_full || accept));
  end

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .run     (state != IDLE),
    .bit_tick(bit_tick)
  );

  // Frame sequencer; tx is always taken straight from a flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      tx       <= 1'b1;
      shifter  <= '0;
      hold     <= '0;
      buf_full <= 1'b0;
      bit_idx  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shifter <= in_data;
            state   <= START;
            tx      <= 1'b0;
            bit_idx <= '0;
          end
        end
        START: begin
          if (bit_tick) begin
            state   <= DATA;
            tx      <= shifter[0];
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (bit_tick) begin
            if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              tx      <= shifter[1];
              shifter <= shifter >> 1;
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end
        end
        STOP: begin
          if (bit_tick) begin
            bit_idx <= '0;
            if (buf_full) begin
              shifter  <= hold;
              buf_full <= 1'b0;
              state    <= START;
              tx       <= 1'b0;
            end else if (accept) begin
              shifter <= in_data;
              state   <= START;
              tx      <= 1'b0;
            end else begin
              state <= IDLE;
              tx    <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase

      // Mid-frame acceptances park in the buffer; an end-of-stop acceptance goes straight to the shifter.
      if (accept && (state != IDLE) && !stop_end) begin
        hold     <= in_data;
        buf_full <= 1'b1;
      end
    end
  end

  assign in_ready = ~buf_full;
  assign busy     = (state != IDLE) || buf_full;
  assign tx_done  = (state == STOP) && bit_tick;

endmodule

// File: tb/tb_count_uart_tx.sv
// Directed bench for count_uart_tx: 4-clock bit period instance plus a 1-clock bit period instance.
module tb_count_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data, in_data1;
  logic       in_valid, in_valid1;
  logic       in_ready, in_ready1;
  logic       tx, tx1;
  logic       busy, busy1;
  logic       tx_done, tx_done1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  count_uart_tx #(.CLKS_PER_BIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .tx(tx), .busy(busy), .tx_done(tx_done)
  );

  count_uart_tx #(.CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .tx(tx1), .busy(busy1), .tx_done(tx_done1)
  );

  // Frame patterns are written stop..start, so bit 0 is the first bit on the line.
  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;

  vec_t vecs[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Offer one byte and hold it until a handshake edge, with a bounded wait.
  task automatic send(input logic [7:0] b);
    logic ok;
    int   n;
    n        = 0;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    do begin
      ok = in_ready;
      tick();
      n++;
    end while (!ok && n < 200);
    in_valid = 1'b0;
    in_data  = 8'hEE;
    check("send_accept", ok, 1'b1);
  endtask

  // Called at the first cycle of a frame; walks all 40 cycles.
  task automatic check_frame(input logic [9:0] fr, input string nm, input int ready_hi);
    for (int c = 0; c < 40; c++) begin
      check({nm, "_tx"}, tx, fr[c/4]);
      check({nm, "_done"}, tx_done, c == 39);
      check({nm, "_ready"}, in_ready, c < ready_hi);
      check({nm, "_busy"}, busy, 1'b1);
      tick();
    end
  endtask

  task automatic check_idle(input string nm);
    check({nm, "_idle_tx"}, tx, 1'b1);
    check({nm, "_idle_busy"}, busy, 1'b0);
    check({nm, "_idle_ready"}, in_ready, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] p55;

    vecs[0] = '{data: 8'hA5, frame: 10'b1_1010_0101_0};
    vecs[1] = '{data: 8'h00, frame: 10'b1_0000_0000_0};
    vecs[2] = '{data: 8'hFF, frame: 10'b1_1111_1111_0};
    vecs[3] = '{data: 8'h3C, frame: 10'b1_0011_1100_0};
    p55     = 10'b1_0101_0101_0;

    // Reset with a byte offered: nothing may be taken.
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hA5;
    in_valid1 = 1'b0;
    in_data1  = 8'h00;
    tick();
    tick();
    check("rst_tx", tx, 1'b1);
    check("rst_ready", in_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", tx_done, 1'b0);
    check("rst_ready1", in_ready1, 1'b1);
    check("rst_tx1", tx1, 1'b1);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    tick();
    check_idle("post_rst");

    // Single frames from the vector table.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = vecs[i].data;
      tick();
      in_valid = 1'b0;
      in_data  = 8'h5A;
      check_frame(vecs[i].frame, $sformatf("single%0d", i), 40);
      check_idle($sformatf("single%0d", i));
    end

    // Back-to-back 0x00 then 0xFF with no gap.
    fork
      begin
        send(8'h00);
        send(8'hFF);
      end
      begin
        tick();
        check_frame(vecs[1].frame, "b2b_f1", 1);
        check_frame(vecs[2].frame, "b2b_f2", 40);
      end
    join
    check_idle("b2b");

    // Backpressure: third byte waits for the buffer to drain.
    fork
      begin
        send(8'hA5);
        send(8'h3C);
        send(8'h81);
      end
      begin
        tick();
        check_frame(vecs[0].frame, "bp_f1", 1);
        check_frame(vecs[3].frame, "bp_f2", 1);
        check_frame(10'b1_1000_0001_0, "bp_f3", 40);
      end
    join
    check_idle("bp");

    // Reset in the middle of 0x3C's first data bit with 0x81 buffered.
    fork
      begin
        send(8'h3C);
        send(8'h81);
      end
      begin
        tick();
        repeat (5) tick();
        check("mid_pre_tx", tx, 1'b0);
        check("mid_pre_busy", busy, 1'b1);
        check("mid_pre_ready", in_ready, 1'b0);
      end
    join
    rst_n = 1'b0;
    tick();
    check("mid_rst_tx", tx, 1'b1);
    check("mid_rst_ready", in_ready, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", tx_done, 1'b0);
    rst_n = 1'b1;
    for (int c = 0; c < 50; c++) begin
      tick();
      check("mid_after_tx", tx, 1'b1);
      check("mid_after_busy", busy, 1'b0);
      check("mid_after_done", tx_done, 1'b0);
    end

    // One clock per bit: tx changes every cycle.
    in_valid1 = 1'b1;
    in_data1  = 8'h55;
    tick();
    in_valid1 = 1'b0;
    in_data1  = 8'h00;
    for (int c = 0; c < 10; c++) begin
      check("cpb1_tx", tx1, p55[c]);
      check("cpb1_done", tx_done1, c == 9);
      check("cpb1_busy", busy1, 1'b1);
      tick();
    end
    check("cpb1_idle_tx", tx1, 1'b1);
    check("cpb1_idle_busy", busy1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
